// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one full-adder
// cell computing a + ~b + 1. Operands and results move over valid/ready handshakes.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid, once raised, holds its payload stable until that edge.
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   nb_sr;
  logic [WIDTH-2:0]   res;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               a_msb;
  logic               b_msb;

  logic               sum_bit;
  logic               carry_next;
  logic [WIDTH-1:0]   res_next;

  // res keeps only the upper WIDTH-1 result bits; the final sum bit completes it.
  always_comb begin
    sum_bit    = a_sr[0] ^ nb_sr[0] ^ carry;
    carry_next = (a_sr[0] & nb_sr[0]) | (a_sr[0] & carry) | (nb_sr[0] & carry);
    res_next   = {sum_bit, res};
  end

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      a_sr      <= '0;
      nb_sr     <= '0;
      res       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            nb_sr    <= ~b;
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
            carry    <= 1'b1;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          carry <= carry_next;
          res   <= res_next[WIDTH-1:1];
          a_sr  <= a_sr >> 1;
          nb_sr <= nb_sr >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            diff      <= res_next;
            borrow    <= ~carry_next;
            overflow  <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
            zero      <= (res_next == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
